// File: rtl/if_pkg.sv
// Shared widths, fetch defaults and the queue entry layout for the fetch stage.
package if_pkg;

  localparam int          WORD_W   = 32;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] RESET_PC = 32'd0;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/if_queue.sv
// Synchronous FIFO of fetch entries; head is registered and holds its last value when empty.
// Clear beats push/pop; push is accepted while full only together with a pop.
module if_queue
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           push_dat,
  input  logic                   pop,
  input  logic                   clear,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head_dat
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  head_q, head_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      // A word pushed into a queue that is empty after this pop becomes the head directly.
      if (do_push && (count_q - CW'(do_pop)) == '0) head_d = push_dat;
      else if (count_d != '0)                       head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign count    = count_q;
  assign head_dat = head_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: PC register, combinational imem access, 1-cycle fetch->decode queue; id_ready low stalls PC once full.
// Taken branch flushes the queue and redirects PC; IF_FETCH_STATS_EN adds saturating fetch/flush/stall counters.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = if_pkg::RESET_PC,
  parameter logic [31:0] PC_STEP  = if_pkg::PC_STEP
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [31:0]            PC_out,
  input  logic [31:0]            instruction,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_addr,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [31:0]            id_instruction,
  output logic [31:0]            id_pc,
  output logic [$clog2(DEPTH):0] queue_count
`ifdef IF_FETCH_STATS_EN
  ,
  output logic [31:0]            stat_fetched,
  output logic [31:0]            stat_flushed,
  output logic [31:0]            stat_stall
`endif
);

  logic [31:0]  pc_q, pc_d;
  logic         q_full, q_empty, push_ok, pop_ok;
  fetch_entry_t push_ent, head;

  assign pop_ok   = !q_empty && id_ready && !branch_taken;
  assign push_ok  = !branch_taken && (!q_full || pop_ok);
  assign push_ent = '{instr: instruction, pc4: pc_q + PC_STEP};

  always_comb begin
    pc_d = pc_q;
    if (branch_taken) pc_d = branch_addr & 32'hFFFF_FFFC;
    else if (push_ok) pc_d = pc_q + PC_STEP;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  if_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .rst_n    (rst),
    .push     (push_ok),
    .push_dat (push_ent),
    .pop      (pop_ok),
    .clear    (branch_taken),
    .full     (q_full),
    .empty    (q_empty),
    .count    (queue_count),
    .head_dat (head)
  );

  assign PC_out         = pc_q;
  assign id_valid       = !q_empty;
  assign id_instruction = head.instr;
  assign id_pc          = head.pc4;

`ifdef IF_FETCH_STATS_EN
  logic [31:0] fetched_q, flushed_q, stall_q;
  logic [32:0] flush_sum;

  assign flush_sum = {1'b0, flushed_q} + 33'(queue_count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
      stall_q   <= '0;
    end else begin
      if (push_ok && fetched_q != '1)              fetched_q <= fetched_q + 32'd1;
      if (branch_taken)                            flushed_q <= flush_sum[32] ? '1 : flush_sum[31:0];
      if (id_valid && !id_ready && stall_q != '1) stall_q   <= stall_q + 32'd1;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_flushed = flushed_q;
  assign stat_stall   = stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed plus randomized bench for if_fetch_queue against a queue-based reference model.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_out;
  logic [31:0] instruction;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic [2:0]  queue_count;
`ifdef IF_FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flushed, stat_stall;
`endif

  logic [31:0] imem [64];
  assign instruction = imem[PC_out[7:2]];

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .PC_out         (PC_out),
    .instruction    (instruction),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instruction (id_instruction),
    .id_pc          (id_pc),
    .queue_count    (queue_count)
`ifdef IF_FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_flushed   (stat_flushed),
    .stat_stall     (stat_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  ent_t        mq[$];
  logic [31:0] mpc;
  ent_t        mhold;
  int unsigned m_fetched, m_flushed, m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc       = 32'd0;
    mhold     = '0;
    m_fetched = 0;
    m_flushed = 0;
    m_stall   = 0;
  endtask

  task automatic model_step(input logic rdy, input logic bt, input logic [31:0] ba);
    logic pop, push;
    if (mq.size() > 0 && !rdy) m_stall++;
    if (bt) begin
      m_flushed += mq.size();
      mq.delete();
      mpc = ba & 32'hFFFF_FFFC;
    end else begin
      pop  = (mq.size() > 0) && rdy;
      push = (mq.size() < DEPTH) || pop;
      if (pop) mq.delete(0);
      if (push) begin
        mq.push_back('{instr: imem[mpc[7:2]], pc4: mpc + 32'd4});
        mpc = mpc + 32'd4;
        m_fetched++;
      end
    end
    if (mq.size() > 0) mhold = mq[0];
  endtask

  task automatic check_outputs();
    chk("id_valid", 32'(id_valid), 32'(mq.size() != 0));
    chk("queue_count", 32'(queue_count), 32'(mq.size()));
    chk("PC_out", PC_out, mpc);
    chk("id_instruction", id_instruction, mhold.instr);
    chk("id_pc", id_pc, mhold.pc4);
`ifdef IF_FETCH_STATS_EN
    chk("stat_fetched", stat_fetched, m_fetched);
    chk("stat_flushed", stat_flushed, m_flushed);
    chk("stat_stall", stat_stall, m_stall);
`endif
  endtask

  // Called at a negedge: check state, drive inputs for the coming posedge, advance model.
  task automatic step(input logic rdy, input logic bt, input logic [31:0] ba);
    check_outputs();
    id_ready     = rdy;
    branch_taken = bt;
    branch_addr  = ba;
    model_step(rdy, bt, ba);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; state must clear without a clock.
  task automatic do_reset();
    rst          = 1'b0;
    branch_taken = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst          = 1'b0;
    id_ready     = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'd0;
    for (int i = 0; i < 64; i++) imem[i] = $urandom;
    imem[0]  = 32'hE3A00014;
    imem[1]  = 32'hE3A01A01;
    imem[5]  = 32'h0000_0000;
    imem[37] = 32'hE2822001;
    model_reset();

    repeat (2) @(negedge clk);
    check_outputs();
    chk("reset_id_instruction", id_instruction, 32'd0);
    rst = 1'b1;

    // Streaming with decode always ready
    step(1'b1, 1'b0, 32'd0);
    chk("stream_c1_instr", id_instruction, 32'hE3A00014);
    chk("stream_c1_pc", id_pc, 32'd4);
    step(1'b1, 1'b0, 32'd0);
    chk("stream_c2_instr", id_instruction, 32'hE3A01A01);
    chk("stream_c2_pc", id_pc, 32'd8);
    chk("stream_c2_pcout", PC_out, 32'd8);
    repeat (5) step(1'b1, 1'b0, 32'd0);

    // Decode frozen from reset: queue fills, PC holds, then drains in order
    do_reset();
    repeat (6) step(1'b0, 1'b0, 32'd0);
    chk("full_count", 32'(queue_count), 32'd4);
    chk("full_pc_hold", PC_out, 32'd16);
    chk("full_head_pc", id_pc, 32'd4);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'd0);
    chk("drain_pcout", PC_out, 32'd32);

    // Branch while full
    repeat (4) step(1'b0, 1'b0, 32'd0);
    chk("pre_branch_count", 32'(queue_count), 32'd4);
    step(1'b0, 1'b1, 32'd148);
    chk("flush_valid", 32'(id_valid), 32'd0);
    chk("flush_count", 32'(queue_count), 32'd0);
    chk("flush_pcout", PC_out, 32'd148);
    step(1'b0, 1'b0, 32'd0);
    chk("target_instr", id_instruction, 32'hE2822001);
    chk("target_pc", id_pc, 32'd152);

    // Back-to-back redirects: last target wins
    step(1'b1, 1'b1, 32'd100);
    step(1'b1, 1'b1, 32'd184);
    chk("b2b_pcout", PC_out, 32'd184);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 32'd0);
      chk("b2b_no_wrong_path", 32'(id_valid && id_pc == 32'd104), 32'd0);
    end

    // Mid-stream reset with three entries queued
    do_reset();
    repeat (3) step(1'b0, 1'b0, 32'd0);
    chk("pre_reset_count", 32'(queue_count), 32'd3);
    do_reset();
    chk("midrst_pcout", PC_out, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    chk("restart_instr", id_instruction, 32'hE3A00014);

    // Unaligned target bits dropped; PC wraps past the top of the address space
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    chk("wrap_pcout_top", PC_out, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'd0);
    chk("wrap_head_pc", id_pc, 32'd0);
    chk("wrap_pcout", PC_out, 32'd0);

    // Stats scenario: 10 pushes, flush of 3 entries, 2 stall cycles
    do_reset();
    repeat (7) step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    chk("stats_pre_flush_count", 32'(queue_count), 32'd3);
    step(1'b1, 1'b1, 32'd0);
`ifdef IF_FETCH_STATS_EN
    chk("stat_fetched_10", stat_fetched, 32'd10);
    chk("stat_flushed_3", stat_flushed, 32'd3);
    chk("stat_stall_2", stat_stall, 32'd2);
`endif

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic        r_rdy, r_bt;
      logic [31:0] r_ba;
      r_rdy = ($urandom_range(0, 3) != 0);
      r_bt  = ($urandom_range(0, 11) == 0);
      r_ba  = $urandom & 32'h0000_00FF;
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(r_rdy, r_bt, r_ba);
    end
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch stage of the ARM-subset pipeline.
- Drives the program counter into the combinational instruction memory and captures the returned word with its PC+4.
- Buffers fetched words in a small queue and hands them to decode over a valid/ready handshake.
- Redirects on taken branches from EX and flushes everything fetched on the wrong path.

Parameters:
- DEPTH, 4, queue entries (power of two, ≥2)
- RESET_PC, 32'd0, PC value after reset
- PC_STEP, 32'd4, PC increment per fetched word

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous reset, active-low (asserted when 0)
- PC_out  output  32  fetch address driven to instruction memory
- instruction  input  32  instruction memory read data, combinational from PC_out, same cycle
- branch_taken  input  1  EX-stage redirect request, one-cycle pulse
- branch_addr  input  32  redirect target, word-aligned
- id_valid  output  1  queue head holds a valid instruction
- id_ready  input  1  decode accepts head this cycle (low = freeze)
- id_instruction  output  32  queue head instruction word
- id_pc  output  32  queue head PC+4
- queue_count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=0, async): PC=RESET_PC, queue empty, id_valid=0, id_instruction=0, id_pc=0, queue_count=0.
- Outputs come straight from registered state, no combinational path from inputs.
  - Exception: PC_out = PC register, and instruction returns combinationally in the same cycle.
- Push:
  - Each cycle with !branch_taken and (!full or pop), write {instruction, PC+PC_STEP} at tail and set PC <= PC+PC_STEP.
  - Otherwise PC holds.
- Pop: occurs when id_valid && id_ready && !branch_taken; head advances.
- Fetch-to-decode latency: a word fetched at cycle N is visible on id_* at cycle N+1 if the queue was empty.
- Full queue with a simultaneous pop: push still occurs and count is unchanged.
- Empty queue: id_valid=0; id_instruction/id_pc hold their last values (don't-care to decode).
- branch_taken has highest priority:
  - PC <= branch_addr.
  - Queue cleared (count=0, id_valid=0 next cycle).
  - No push and no pop that cycle.
  - The target word is fetched and pushed on the next cycle.
- Back-to-back branch_taken pulses: the last one wins; the queue stays empty while branch_taken is high.
- PC arithmetic is 32-bit unsigned and wraps 0xFFFFFFFC -> 0x00000000. branch_addr[1:0] is ignored and forced to 0.
- An instruction of 32'd0 (memory default) is queued like any other word; no special decode.
- Reset asserted mid-operation returns all state to reset values immediately; in-flight queue contents are discarded.
- Queue pointers wrap modulo DEPTH. Occupancy uses a separate count register, so the full/empty distinction needs no pointer extra bit.

Optional Feature:
- Macro IF_FETCH_STATS_EN.
- When defined, adds three 32-bit saturating counters and output ports:
  - stat_fetched: pushes.
  - stat_flushed: entries discarded by branch_taken, i.e. count at the flush cycle.
  - stat_stall: cycles with id_valid && !id_ready.
- Counters reset to 0.
- When undefined, no counters and no ports exist; the rest of the behaviour is identical.

Decomposition:
- Package if_pkg:
  - WORD_W=32, PC_STEP, RESET_PC.
  - Typedef fetch_entry_t {logic [31:0] instr; logic [31:0] pc4;}.
- Sub-module if_queue:
  - Generic synchronous FIFO of fetch_entry_t with push, pop, clear, full, empty, count.
  - Same-cycle push+pop when full permitted; clear has priority over push and pop.
- if_fetch_queue holds the PC register, the redirect logic and the stats.

Test Plan:
- Reset release, id_ready=1 -> cycle 1: id_instruction=0xE3A00014, id_pc=4; cycle 2: 0xE3A01A01, id_pc=8; PC_out steps 0,4,8,...
- id_ready=0 for 6 cycles after reset -> queue_count reaches 4 at PC_out=16 and PC holds; on id_ready=1, heads pop in order with id_pc=4,8,12,16, and PC advances one step per pop.
- Queue full plus branch_taken with branch_addr=148 -> next cycle id_valid=0, count=0, PC_out=148; the following cycle the head is 0xE2822001 with id_pc=152.
- branch_taken pulses at cycles N (addr 100) and N+1 (addr 184) -> PC_out=184 at N+2 and no word from address 100 ever appears on id_*.
- rst asserted mid-stream with count=3 -> immediately id_valid=0, PC_out=0, count=0; after release, fetch restarts at 0xE3A00014.
- With IF_FETCH_STATS_EN defined: 10 pushes, a flush of 3 entries and 2 stall cycles -> stat_fetched=10, stat_flushed=3, stat_stall=2.
